// File: rtl/y_div_seq.sv
// -----------------------------------------------------------------------------
// y_div_seq : multi-cycle restoring divider controller
//
// Produces one quotient bit per clock by running a single W-bit add/subtract
// operation (a + ~b + 1 with carry-out when ctrl=1). The core issues a request
// on start/dividend/divisor while busy is low. W iterations later, done pulses
// for one cycle and quotient/remainder become valid. A zero divisor skips the
// iterations and completes through a single ZERO cycle.
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   start        in   1  request, sampled only while busy==0 (IDLE or FIN)
//   dividend     in   W  numerator, captured on an accepted start
//   divisor      in   W  denominator, captured on an accepted start
//   sgn          in   1  signed divide request (only with DIV_SIGNED_EN)
//   busy         out  1  high while a division is in flight (RUN/ZERO)
//   done         out  1  one-cycle pulse, results valid from this cycle
//   quotient     out  W  result, held until the next completion
//   remainder    out  W  result, held until the next completion
//   div_by_zero  out  1  set with done for a zero divisor, cleared on accept
//
// Configuration macro
//   DIV_SIGNED_EN : adds the sgn input. Signed requests divide operand
//                   magnitudes and fix the result signs on completion.
// -----------------------------------------------------------------------------
module y_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Shared add/subtract datapath: ctrl=1 gives a + ~b + 1, bit W is carry-out.
  function automatic logic [W:0] add_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         ctrl);
    logic [W-1:0] b_op;
    b_op = ctrl ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + {{W{1'b0}}, ctrl};
  endfunction

  state_e         state_q, state_d;
  logic [W-1:0]   p_q, p_d;          // partial remainder
  logic [W-1:0]   q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [W-1:0]   d_q, d_d;          // divisor magnitude
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_n_q, neg_n_d;  // signed request with negative dividend
  logic           neg_d_q, neg_d_d;  // signed request with negative divisor
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sgn_s;
  logic           accept_s;
  logic [W-1:0]   s_s;
  logic           spill_s;
  logic [W:0]     sub_w_s;
  logic           take_s;
  logic [W-1:0]   p_step_s;
  logic [W-1:0]   q_step_s;
  logic [W:0]     qfin_w_s;
  logic [W:0]     rfin_w_s;
  logic [W-1:0]   q_final_s;
  logic [W-1:0]   r_final_s;
  logic [W:0]     neg_dvd_w_s;
  logic [W:0]     neg_dsr_w_s;
  logic           unused_cout_s;

`ifdef DIV_SIGNED_EN
  assign sgn_s = sgn;
`else
  assign sgn_s = 1'b0;
`endif

  // Carry-outs of the negation uses carry no information.
  assign unused_cout_s = qfin_w_s[W] ^ rfin_w_s[W] ^ neg_dvd_w_s[W] ^ neg_dsr_w_s[W];

  // A request is taken whenever the unit is not busy (IDLE or FIN).
  assign accept_s = start & ((state_q == S_IDLE) | (state_q == S_FIN));

  // One restoring iteration plus the sign fix-up applied on completion.
  always_comb begin
    s_s      = {p_q[W-2:0], q_q[W-1]};
    // Bit shifted out of P: S is really W+1 bits wide when D >= 2^(W-1).
    spill_s  = p_q[W-1];
    sub_w_s  = add_sub(s_s, d_q, 1'b1);
    take_s   = spill_s | sub_w_s[W];
    p_step_s = take_s ? sub_w_s[W-1:0] : s_s;
    q_step_s = {q_q[W-2:0], take_s};
    qfin_w_s = add_sub({W{1'b0}}, q_step_s, 1'b1);
    rfin_w_s = add_sub({W{1'b0}}, p_step_s, 1'b1);
    q_final_s = (neg_n_q ^ neg_d_q) ? qfin_w_s[W-1:0] : q_step_s;
    r_final_s = neg_n_q ? rfin_w_s[W-1:0] : p_step_s;
  end

  // Operand magnitudes for a signed request.
  always_comb begin
    neg_dvd_w_s = add_sub({W{1'b0}}, dividend, 1'b1);
    neg_dsr_w_s = add_sub({W{1'b0}}, divisor, 1'b1);
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    neg_n_d = neg_n_q;
    neg_d_d = neg_d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        p_d   = p_step_s;
        q_d   = q_step_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
          quo_d   = q_final_s;
          rem_d   = r_final_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_ZERO: begin
        // Q still holds the raw dividend: a zero divisor is never negated.
        state_d = S_FIN;
        quo_d   = {W{1'b1}};
        rem_d   = q_q;
        dbz_d   = 1'b1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting a request overrides the IDLE/FIN transitions above.
    if (accept_s) begin
      p_d     = {W{1'b0}};
      cnt_d   = CNT_ZERO;
      dbz_d   = 1'b0;
      neg_n_d = sgn_s & dividend[W-1];
      neg_d_d = sgn_s & divisor[W-1];
      d_d     = (sgn_s & divisor[W-1]) ? neg_dsr_w_s[W-1:0] : divisor;
      if (divisor == {W{1'b0}}) begin
        state_d = S_ZERO;
        q_d     = dividend;
      end else begin
        state_d = S_RUN;
        q_d     = (sgn_s & dividend[W-1]) ? neg_dvd_w_s[W-1:0] : dividend;
      end
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d == S_RUN) | (state_d == S_ZERO);
    done_d = (state_d == S_FIN);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= {W{1'b0}};
      q_q     <= {W{1'b0}};
      d_q     <= {W{1'b0}};
      cnt_q   <= CNT_ZERO;
      neg_n_q <= 1'b0;
      neg_d_q <= 1'b0;
      quo_q   <= {W{1'b0}};
      rem_q   <= {W{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      neg_n_q <= neg_n_d;
      neg_d_q <= neg_d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_y_div_seq.sv
// -----------------------------------------------------------------------------
// tb_y_div_seq : self-checking bench for y_div_seq (W=32).
// Directed cases plus randomized operands compared with a plain-arithmetic
// reference (/ and %, with the zero-divisor and signed-overflow rules).
// -----------------------------------------------------------------------------
module tb_y_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic         sgn;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_errors;

  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_dbz;
  int           exp_lat;

  y_div_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .sgn         (sgn),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result: plain arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_dbz = 1'b0;
    exp_lat = W + 1;
    if (b == 0) begin
      exp_q = {W{1'b1}};
      exp_r = a;
      exp_dbz = 1'b1;
      exp_lat = 2;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exp_q = 32'h8000_0000;
      exp_r = 32'h0000_0000;
    end else if (s) begin
      exp_q = $signed(a) / $signed(b);
      exp_r = $signed(a) % $signed(b);
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end
  endtask

  // Present a request; now=1 drives it in the current (already sampled) cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
`ifdef DIV_SIGNED_EN
    sgn = s;
`endif
    model(a, b, s);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done (bounded), checking latency and busy; poke>0 issues an
  // extra start pulse in that cycle which must be ignored.
  task automatic wait_done(input string tag, input int poke);
    int  cyc;
    int  busy_bad;
    bit  seen;
    cyc = 0;
    busy_bad = 0;
    seen = 0;
    while (!seen && cyc < W + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq({tag, "_dbz_clr"}, {63'd0, div_by_zero}, 64'd0);
      if (done) seen = 1;
      else if (!busy) busy_bad++;
      if (!seen && cyc == poke) begin
        start = 1'b1;
        dividend = 32'd7;
        divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_busy_fin"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_q"}, {32'd0, quotient}, {32'd0, exp_q});
    check_eq({tag, "_r"}, {32'd0, remainder}, {32'd0, exp_r});
    check_eq({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
  endtask

  // Full request: accept, complete, then confirm done is a single pulse.
  task automatic run_div(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    start_op(a, b, s, 1'b0);
    wait_done(tag, 0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_hold"}, {32'd0, quotient}, {32'd0, exp_q});
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           kind;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_q", {32'd0, quotient}, 64'd0);
    check_eq("rst_r", {32'd0, remainder}, 64'd0);
    check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);

    run_div("d100_7", 32'd100, 32'd7, 1'b0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("dspill", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_div("d5_0", 32'd5, 32'd0, 1'b0);
    run_div("d9_3", 32'd9, 32'd3, 1'b0);

    // Start during iteration 5 must be ignored.
    start_op(32'd1000, 32'd10, 1'b0, 1'b0);
    wait_done("ign", 5);
    // Back-to-back: request held in the FIN cycle.
    start_op(32'd7, 32'd7, 1'b0, 1'b1);
    wait_done("b2b", 0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start_op(32'd1000, 32'd10, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_q", {32'd0, quotient}, 64'd0);
    check_eq("abort_r", {32'd0, remainder}, 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("abort_nodone", 64'(done_cnt), 64'd0);

`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      kind = $urandom_range(0, 7);
      if (kind == 0) rb = 32'd0;
      else if (kind <= 2) rb = 32'($urandom_range(1, 15));
      else if (kind <= 4) rb = $urandom | 32'h8000_0000;
      else rb = $urandom >> $urandom_range(0, 31);
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_div("rand", ra, rb, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
